// File: rtl/iq_pkg.sv
// iq_pkg: shared types and default widths for the issue queue and its neighbours.
package iq_pkg;

  localparam int IQ_OP_W    = 4;
  localparam int IQ_TAG_W   = 6;
  localparam int IQ_ROB_W   = 6;
  localparam int IQ_DATA_W  = 32;
  // Number of result buses; the functional units drive the same count.
  localparam int IQ_NUM_CDB = 3;

  // One queue slot. Entry widths follow the package defaults above.
  typedef struct packed {
    logic                 valid;
    logic [IQ_OP_W-1:0]   op;
    logic [IQ_TAG_W-1:0]  tag_rd;
    logic [IQ_TAG_W-1:0]  tag_rs1;
    logic [IQ_TAG_W-1:0]  tag_rs2;
    logic                 rdy1;
    logic                 rdy2;
    logic [IQ_DATA_W-1:0] data1;
    logic [IQ_DATA_W-1:0] data2;
    logic [IQ_ROB_W-1:0]  rob_index;
  } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// iq_select: combinational oldest-first picker. Each ready FU, in ascending
// port order, takes the lowest-index (oldest) eligible entry not yet taken.
module iq_select #(
  parameter int DEPTH  = 8,
  parameter int NUM_FU = 3
) (
  input  logic                     en,
  input  logic [DEPTH-1:0]         eligible,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        grant,
  output logic [$clog2(DEPTH)-1:0] grant_idx [NUM_FU]
);

  logic [DEPTH-1:0] taken;
  logic             found;

  // Walk FUs in order, each claiming the oldest still-unclaimed eligible entry.
  always_comb begin
    taken = '0;
    grant = '0;
    found = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      grant_idx[f] = '0;
      found = 1'b0;
      if (en && fu_ready[f]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && eligible[i] && !taken[i]) begin
            found        = 1'b1;
            grant[f]     = 1'b1;
            grant_idx[f] = ($clog2(DEPTH))'(i);
            taken[i]     = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/issue_queue_multi.sv
// issue_queue_multi: collapsing, age-ordered issue queue with NUM_CDB wakeup
// ports and up to NUM_FU registered issues per cycle. Slot 0 is always the
// oldest entry. Optional macro ISSUE_QUEUE_WAKEUP_BYPASS_EN lets select see
// this cycle's CDB broadcasts for back-to-back wakeup-to-issue.
module issue_queue_multi
  import iq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_FU  = 3,
  parameter int NUM_CDB = IQ_NUM_CDB,
  parameter int DATA_W  = IQ_DATA_W,
  parameter int TAG_W   = IQ_TAG_W,
  parameter int ROB_W   = IQ_ROB_W,
  parameter int OP_W    = IQ_OP_W,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall_in,
  input  logic               in_valid,
  input  logic [OP_W-1:0]    op,
  input  logic [TAG_W-1:0]   tag_rd,
  input  logic [TAG_W-1:0]   tag_rs1,
  input  logic [TAG_W-1:0]   tag_rs2,
  input  logic               rs1_ready,
  input  logic               rs2_ready,
  input  logic [DATA_W-1:0]  data_rs1,
  input  logic [DATA_W-1:0]  data_rs2,
  input  logic [ROB_W-1:0]   rob_index,
  input  logic [TAG_W-1:0]   cdb_tags [NUM_CDB],
  input  logic [DATA_W-1:0]  cdb_data [NUM_CDB],
  input  logic [NUM_CDB-1:0] cdb_valid,
  input  logic [NUM_FU-1:0]  fu_ready,
  output logic [OP_W-1:0]    fu_op [NUM_FU],
  output logic [DATA_W-1:0]  fu_rs1 [NUM_FU],
  output logic [DATA_W-1:0]  fu_rs2 [NUM_FU],
  output logic [TAG_W-1:0]   fu_tags [NUM_FU],
  output logic [ROB_W-1:0]   fu_rob_index [NUM_FU],
  output logic [NUM_FU-1:0]  fu_valid,
  output logic               iq_stall,
  output logic [CNT_W-1:0]   count
);

  iq_entry_t entries_q [DEPTH];
  iq_entry_t entries_d [DEPTH];
  iq_entry_t woke      [DEPTH];
  iq_entry_t sel_src   [DEPTH];
  iq_entry_t in_entry;

  logic [CNT_W-1:0]  count_q, count_d, keep_cnt;
  logic [DEPTH-1:0]  eligible, issued;
  logic [NUM_FU-1:0] grant;
  logic [IDX_W-1:0]  grant_idx [NUM_FU];
  logic              issue_en, dispatch_en;

  logic [OP_W-1:0]   fu_op_d [NUM_FU],        fu_op_q [NUM_FU];
  logic [DATA_W-1:0] fu_rs1_d [NUM_FU],       fu_rs1_q [NUM_FU];
  logic [DATA_W-1:0] fu_rs2_d [NUM_FU],       fu_rs2_q [NUM_FU];
  logic [TAG_W-1:0]  fu_tags_d [NUM_FU],      fu_tags_q [NUM_FU];
  logic [ROB_W-1:0]  fu_rob_index_d [NUM_FU], fu_rob_index_q [NUM_FU];
  logic [NUM_FU-1:0] fu_valid_d, fu_valid_q;

  assign iq_stall     = (count_q == CNT_W'(DEPTH));
  assign count        = count_q;
  assign issue_en     = ~stall_in & ~flush;
  assign dispatch_en  = in_valid & ~stall_in & ~iq_stall;
  assign fu_op        = fu_op_q;
  assign fu_rs1       = fu_rs1_q;
  assign fu_rs2       = fu_rs2_q;
  assign fu_tags      = fu_tags_q;
  assign fu_rob_index = fu_rob_index_q;
  assign fu_valid     = fu_valid_q;

  // Build the incoming entry, capturing any same-cycle CDB result (lowest port wins).
  always_comb begin
    in_entry           = '0;
    in_entry.valid     = 1'b1;
    in_entry.op        = op;
    in_entry.tag_rd    = tag_rd;
    in_entry.tag_rs1   = tag_rs1;
    in_entry.tag_rs2   = tag_rs2;
    in_entry.rdy1      = rs1_ready;
    in_entry.rdy2      = rs2_ready;
    in_entry.data1     = data_rs1;
    in_entry.data2     = data_rs2;
    in_entry.rob_index = rob_index;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && !rs1_ready && cdb_tags[c] == tag_rs1) begin
        in_entry.rdy1  = 1'b1;
        in_entry.data1 = cdb_data[c];
      end
      if (cdb_valid[c] && !rs2_ready && cdb_tags[c] == tag_rs2) begin
        in_entry.rdy2  = 1'b1;
        in_entry.data2 = cdb_data[c];
      end
    end
  end

  // Wakeup view of every stored entry; descending scan so the lowest CDB port wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = entries_q[i];
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] && entries_q[i].valid && !entries_q[i].rdy1 &&
            cdb_tags[c] == entries_q[i].tag_rs1) begin
          woke[i].rdy1  = 1'b1;
          woke[i].data1 = cdb_data[c];
        end
        if (cdb_valid[c] && entries_q[i].valid && !entries_q[i].rdy2 &&
            cdb_tags[c] == entries_q[i].tag_rs2) begin
          woke[i].rdy2  = 1'b1;
          woke[i].data2 = cdb_data[c];
        end
      end
    end
  end

  // Choose the view select works from and flag entries with both operands ready.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
      sel_src[i] = woke[i];
`else
      sel_src[i] = entries_q[i];
`endif
      eligible[i] = sel_src[i].valid & sel_src[i].rdy1 & sel_src[i].rdy2;
    end
  end

  iq_select #(
    .DEPTH  (DEPTH),
    .NUM_FU (NUM_FU)
  ) u_select (
    .en        (issue_en),
    .eligible  (eligible),
    .fu_ready  (fu_ready),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Mark which slots leave the queue this cycle.
  always_comb begin
    issued = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (grant[f]) issued[grant_idx[f]] = 1'b1;
    end
  end

  // Collapse survivors toward slot 0 in age order, then append the dispatch.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) entries_d[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (woke[i].valid && !issued[i]) begin
        entries_d[keep_cnt[IDX_W-1:0]] = woke[i];
        keep_cnt = keep_cnt + CNT_W'(1);
      end
    end
    if (dispatch_en) entries_d[keep_cnt[IDX_W-1:0]] = in_entry;
    count_d = keep_cnt + CNT_W'(dispatch_en);
  end

  // Gather issued payloads per FU; unused ports carry zeros.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      fu_valid_d[f]     = grant[f];
      fu_op_d[f]        = '0;
      fu_rs1_d[f]       = '0;
      fu_rs2_d[f]       = '0;
      fu_tags_d[f]      = '0;
      fu_rob_index_d[f] = '0;
      if (grant[f]) begin
        fu_op_d[f]        = sel_src[grant_idx[f]].op;
        fu_rs1_d[f]       = sel_src[grant_idx[f]].data1;
        fu_rs2_d[f]       = sel_src[grant_idx[f]].data2;
        fu_tags_d[f]      = sel_src[grant_idx[f]].tag_rd;
        fu_rob_index_d[f] = sel_src[grant_idx[f]].rob_index;
      end
    end
  end

  // Queue storage and occupancy; flush empties the queue ahead of any update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  // Registered issue ports; each grant is presented for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < NUM_FU; f++) begin
        fu_op_q[f]        <= '0;
        fu_rs1_q[f]       <= '0;
        fu_rs2_q[f]       <= '0;
        fu_tags_q[f]      <= '0;
        fu_rob_index_q[f] <= '0;
      end
      fu_valid_q <= '0;
    end else begin
      fu_op_q        <= fu_op_d;
      fu_rs1_q       <= fu_rs1_d;
      fu_rs2_q       <= fu_rs2_d;
      fu_tags_q      <= fu_tags_d;
      fu_rob_index_q <= fu_rob_index_d;
      fu_valid_q     <= fu_valid_d;
    end
  end

endmodule

// File: tb/tb_issue_queue_multi.sv
// tb_issue_queue_multi: directed and random checking of issue_queue_multi
// against a queue-based reference model of the dispatch/wakeup/issue rules.
module tb_issue_queue_multi;

  localparam int DEPTH   = 8;
  localparam int NUM_FU  = 3;
  localparam int NUM_CDB = 3;
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk, rst, flush, stall_in, in_valid;
  logic [3:0]  op;
  logic [5:0]  tag_rd, tag_rs1, tag_rs2;
  logic        rs1_ready, rs2_ready;
  logic [31:0] data_rs1, data_rs2;
  logic [5:0]  rob_index;
  logic [5:0]  cdb_tags [NUM_CDB];
  logic [31:0] cdb_data [NUM_CDB];
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_FU-1:0]  fu_ready;
  logic [3:0]  fu_op [NUM_FU];
  logic [31:0] fu_rs1 [NUM_FU];
  logic [31:0] fu_rs2 [NUM_FU];
  logic [5:0]  fu_tags [NUM_FU];
  logic [5:0]  fu_rob_index [NUM_FU];
  logic [NUM_FU-1:0] fu_valid;
  logic        iq_stall;
  logic [3:0]  count;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  rd, s1, s2, rob;
    bit          r1, r2;
    logic [31:0] d1, d2;
  } mentry_t;

  mentry_t     mq[$];
  bit          exp_v   [NUM_FU];
  logic [79:0] exp_pay [NUM_FU];
  int          checks = 0;
  int          errors = 0;

  issue_queue_multi dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .in_valid(in_valid),
    .op(op), .tag_rd(tag_rd), .tag_rs1(tag_rs1), .tag_rs2(tag_rs2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .data_rs1(data_rs1), .data_rs2(data_rs2),
    .rob_index(rob_index), .cdb_tags(cdb_tags), .cdb_data(cdb_data), .cdb_valid(cdb_valid),
    .fu_ready(fu_ready), .fu_op(fu_op), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_tags(fu_tags),
    .fu_rob_index(fu_rob_index), .fu_valid(fu_valid), .iq_stall(iq_stall), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Any not-ready source matching a valid broadcast takes its value; first (lowest) port wins.
  function automatic mentry_t wakeUp(mentry_t e);
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cdb_valid[c]) begin
        if (!e.r1 && cdb_tags[c] == e.s1) begin e.r1 = 1'b1; e.d1 = cdb_data[c]; end
        if (!e.r2 && cdb_tags[c] == e.s2) begin e.r2 = 1'b1; e.d2 = cdb_data[c]; end
      end
    end
    return e;
  endfunction

  task automatic modelReset();
    mq.delete();
    for (int f = 0; f < NUM_FU; f++) begin exp_v[f] = 1'b0; exp_pay[f] = '0; end
  endtask

  // Advance the reference model across one rising edge using the current inputs.
  task automatic modelEdge();
    mentry_t woke[$];
    mentry_t nq[$];
    mentry_t src, ne;
    bit      taken [DEPTH];
    int      old_size;
    old_size = mq.size();
    for (int f = 0; f < NUM_FU; f++) begin exp_v[f] = 1'b0; exp_pay[f] = '0; end
    if (flush) begin mq.delete(); return; end
    for (int i = 0; i < old_size; i++) woke.push_back(wakeUp(mq[i]));
    for (int i = 0; i < DEPTH; i++) taken[i] = 1'b0;
    if (!stall_in) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (fu_ready[f]) begin
          for (int i = 0; i < old_size; i++) begin
            src = BYPASS ? woke[i] : mq[i];
            if (!taken[i] && src.r1 && src.r2) begin
              taken[i]   = 1'b1;
              exp_v[f]   = 1'b1;
              exp_pay[f] = {src.op, src.d1, src.d2, src.rd, src.rob};
              break;
            end
          end
        end
      end
    end
    for (int i = 0; i < old_size; i++) if (!taken[i]) nq.push_back(woke[i]);
    if (in_valid && !stall_in && old_size < DEPTH) begin
      ne.op = op; ne.rd = tag_rd; ne.s1 = tag_rs1; ne.s2 = tag_rs2; ne.rob = rob_index;
      ne.r1 = rs1_ready; ne.r2 = rs2_ready; ne.d1 = data_rs1; ne.d2 = data_rs2;
      nq.push_back(wakeUp(ne));
    end
    mq = nq;
  endtask

  task automatic compareModel();
    checkOutput("count", 128'(count), 128'(mq.size()));
    checkOutput("iq_stall", 128'(iq_stall), 128'(mq.size() == DEPTH));
    for (int f = 0; f < NUM_FU; f++) begin
      checkOutput($sformatf("fu_valid%0d", f), 128'(fu_valid[f]), 128'(exp_v[f]));
      if (exp_v[f])
        checkOutput($sformatf("fu_payload%0d", f),
                    128'({fu_op[f], fu_rs1[f], fu_rs2[f], fu_tags[f], fu_rob_index[f]}),
                    128'(exp_pay[f]));
    end
  endtask

  // One clock: model the edge, let the DUT take it, compare #1 later, return at negedge.
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
    compareModel();
    @(negedge clk);
  endtask

  task automatic setDispatch(input logic v, input logic [3:0] o, input logic [5:0] rd,
                             input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                             input logic r2, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [5:0] rob);
    in_valid = v; op = o; tag_rd = rd; tag_rs1 = s1; rs1_ready = r1; tag_rs2 = s2;
    rs2_ready = r2; data_rs1 = d1; data_rs2 = d2; rob_index = rob;
  endtask

  task automatic randomInputs(input int n);
    int r;
    flush    = ($urandom_range(0, 99) < 2);
    stall_in = ($urandom_range(0, 99) < 10);
    setDispatch($urandom_range(0, 99) < 65, 4'($urandom_range(0, 15)),
                6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, $urandom, $urandom, 6'($urandom_range(0, 63)));
    r = $urandom_range(0, 7);
    for (int c = 0; c < NUM_CDB; c++) begin
      cdb_valid[c] = ($urandom_range(0, 99) < 40);
      cdb_tags[c]  = 6'((r + 3 * c) % 8);
      cdb_data[c]  = $urandom;
    end
    for (int f = 0; f < NUM_FU; f++)
      fu_ready[f] = (n < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 30);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall_in = 1'b0; cdb_valid = '0; fu_ready = '1;
    for (int c = 0; c < NUM_CDB; c++) begin cdb_tags[c] = '0; cdb_data[c] = '0; end
    setDispatch(1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 32'd0, 32'd0, 6'd0);
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_count", 128'(count), 128'(0));
    checkOutput("reset_stall", 128'(iq_stall), 128'(0));
    checkOutput("reset_valid", 128'(fu_valid), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] ready dispatch");
    for (int k = 1; k <= 3; k++) begin
      setDispatch(1'b1, 4'(k), 6'(k), 6'd9, 1'b1, 6'd9, 1'b1, 32'(100 + k), 32'(200 + k), 6'(10 + k));
      applyStimulus();
      if (k >= 2) begin
        checkOutput("rdy_valid", 128'(fu_valid), 128'(3'b001));
        checkOutput("rdy_tag_rob", 128'({fu_tags[0], fu_rob_index[0]}), 128'({6'(k - 1), 6'(9 + k)}));
      end
    end
    in_valid = 1'b0;
    applyStimulus();
    checkOutput("rdy_tag_rob_last", 128'({fu_tags[0], fu_rob_index[0]}), 128'({6'd3, 6'd13}));

    $display("[TB] wakeup latency");
    setDispatch(1'b1, 4'd2, 6'd7, 6'd5, 1'b0, 6'd6, 1'b1, 32'd0, 32'h55, 6'd20);
    applyStimulus();
    in_valid = 1'b0;
    applyStimulus();
    cdb_valid = 3'b010; cdb_tags[1] = 6'd5; cdb_data[1] = 32'h1234;
    applyStimulus();
    cdb_valid = '0;
    if (!BYPASS) begin
      checkOutput("wake_early", 128'(fu_valid[0]), 128'(0));
      applyStimulus();
    end
    checkOutput("wake_valid", 128'(fu_valid[0]), 128'(1));
    checkOutput("wake_rs1", 128'(fu_rs1[0]), 128'(32'h1234));
    checkOutput("wake_tag", 128'(fu_tags[0]), 128'(7));
    applyStimulus();

    $display("[TB] oldest first with skipped FU");
    fu_ready = 3'b000;
    for (int k = 0; k < 4; k++) begin
      setDispatch(1'b1, 4'd1, 6'(21 + k), 6'd0, 1'b1, 6'd0, 1'b1, 32'(k), 32'(k), 6'(k));
      applyStimulus();
    end
    in_valid = 1'b0; fu_ready = 3'b101;
    applyStimulus();
    checkOutput("skip_valid", 128'(fu_valid), 128'(3'b101));
    checkOutput("skip_tags", 128'({fu_tags[0], fu_tags[2]}), 128'({6'd21, 6'd22}));
    checkOutput("skip_count", 128'(count), 128'(2));
    fu_ready = 3'b111;
    repeat (2) applyStimulus();

    $display("[TB] full queue");
    for (int k = 0; k < DEPTH; k++) begin
      setDispatch(1'b1, 4'd3, 6'(50 + k), 6'(30 + k), 1'b0, 6'd0, 1'b1, 32'd0, 32'(k), 6'(k));
      applyStimulus();
    end
    checkOutput("full_count", 128'(count), 128'(DEPTH));
    checkOutput("full_stall", 128'(iq_stall), 128'(1));
    setDispatch(1'b1, 4'd3, 6'd60, 6'd0, 1'b1, 6'd0, 1'b1, 32'd1, 32'd1, 6'd1);
    applyStimulus();
    checkOutput("full_refuse", 128'(count), 128'(DEPTH));
    in_valid = 1'b0;
    cdb_valid = 3'b001; cdb_tags[0] = 6'd33; cdb_data[0] = 32'hABCD;
    applyStimulus();
    cdb_valid = '0;
    if (!BYPASS) applyStimulus();
    checkOutput("full_issue_tag", 128'(fu_tags[0]), 128'(53));
    checkOutput("full_after_count", 128'(count), 128'(DEPTH - 1));
    checkOutput("full_after_stall", 128'(iq_stall), 128'(0));

    $display("[TB] flush with dispatch and CDB");
    flush = 1'b1;
    setDispatch(1'b1, 4'd4, 6'd61, 6'd0, 1'b1, 6'd0, 1'b1, 32'd2, 32'd2, 6'd2);
    cdb_valid = 3'b001; cdb_tags[0] = 6'd30; cdb_data[0] = 32'h77;
    applyStimulus();
    checkOutput("flush_count", 128'(count), 128'(0));
    checkOutput("flush_valid", 128'(fu_valid), 128'(0));
    flush = 1'b0; in_valid = 1'b0; cdb_valid = '0;

    $display("[TB] asynchronous reset mid-run");
    for (int k = 0; k < 5; k++) begin
      setDispatch(1'b1, 4'd5, 6'(40 + k), 6'(40 + k), 1'b0, 6'd0, 1'b1, 32'd0, 32'd0, 6'(k));
      applyStimulus();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_count", 128'(count), 128'(0));
    checkOutput("arst_stall", 128'(iq_stall), 128'(0));
    checkOutput("arst_valid", 128'(fu_valid), 128'(0));
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    cdb_valid = 3'b001; cdb_tags[0] = 6'd40; cdb_data[0] = 32'h9;
    applyStimulus();
    cdb_valid = '0;
    applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      randomInputs(n);
      applyStimulus();
    end
    flush = 1'b0; stall_in = 1'b0; in_valid = 1'b0; cdb_valid = '0; fu_ready = '1;
    repeat (3) applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue_multi.md
Name: issue_queue_multi

Overview:
- Parametrised successor to the current single-configuration issue queue.
- Holds renamed, dispatched instructions in a collapsing, age-ordered buffer and captures operands from NUM_CDB common-data-bus ports.
- Issues up to NUM_FU ready instructions per cycle, oldest first, to the functional units that are ready.
- Sits between rename/operand read (ARF+ROB) and the functional units.

Parameters:
- DEPTH, 8: entries; power of two not required, minimum 2.
- NUM_FU, 3: issue ports.
- NUM_CDB, 3: CDB wakeup ports.
- DATA_W, 32: operand width.
- TAG_W, 6: physical tag width.
- ROB_W, 6: ROB index width.
- OP_W, 4: ALU select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- stall_in  in  1  blocks dispatch and issue this cycle.
- in_valid  in  1  dispatch request.
- op  in  OP_W  ALU select.
- tag_rd  in  TAG_W  destination tag.
- tag_rs1, tag_rs2  in  TAG_W  source tags.
- rs1_ready, rs2_ready  in  1  source value already resolved (ARF/ROB/immediate).
- data_rs1, data_rs2  in  DATA_W  resolved source values; rs2 carries imm when immediate form.
- rob_index  in  ROB_W  ROB slot of the instruction.
- cdb_tags[NUM_CDB]  in  TAG_W  broadcast tags.
- cdb_data[NUM_CDB]  in  DATA_W  broadcast values.
- cdb_valid[NUM_CDB]  in  1  broadcast valid.
- fu_ready[NUM_FU]  in  1  FU can accept an op next edge.
- fu_op[NUM_FU]  out  OP_W  issued op.
- fu_rs1, fu_rs2 [NUM_FU]  out  DATA_W  issued operands.
- fu_tags[NUM_FU]  out  TAG_W  issued destination tag.
- fu_rob_index[NUM_FU]  out  ROB_W  issued ROB index.
- fu_valid[NUM_FU]  out  1  issue valid.
- iq_stall  out  1  queue full; dispatch refused.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst=0, async): all entries invalid, count=0, iq_stall=0, all fu_* outputs 0. Flush does the same synchronously; flush has priority over dispatch and issue in the same cycle.
- Storage: slot 0 always holds the oldest entry. Valid entries are contiguous from slot 0.
- Dispatch: accepted when in_valid & ~stall_in & ~iq_stall. Written at slot (count − issued_this_cycle) after collapse. Dispatch and issue may occur in the same cycle.
- Dispatch bypass: an incoming source that is not ready and matches a valid CDB tag this cycle is stored ready, with that CDB's data.
- Wakeup: every cycle, each valid, not-ready source compares against all cdb ports. On a match it sets ready and captures data at the edge.
  - Multiple CDB matches on the same tag are illegal; the lowest port index wins.
  - Tag 0 is a valid tag; no special casing.
- Select: an entry is eligible when it is valid and both sources are ready in registered state.
  - The k-th oldest eligible entry goes to the k-th FU (ascending index) with fu_ready=1. FUs with fu_ready=0 are skipped.
  - Issued entries are removed; remaining entries shift down preserving order.
- Issue outputs are registered. The entry is selected in cycle N; fu_* and fu_valid are presented after edge N+1, for one cycle only.
  - fu_valid=0 for unused ports and whenever stall_in=1.
- Latency: CDB broadcast at edge E → entry ready after E → fu_valid asserted after E+1 (2 cycles from broadcast).
- iq_stall = (count == DEPTH), computed from registered count. It stays asserted in a full cycle even if an issue frees a slot, so dispatch is refused that cycle.
- count update: count_next = count − issued + dispatched.
- in_valid while iq_stall=1: request ignored, no state change; upstream must hold.
- stall_in: wakeup continues; dispatch and issue are suppressed.

Optional Feature:
- ISSUE_QUEUE_WAKEUP_BYPASS_EN
  - Defined: select also treats sources matching a valid CDB tag this cycle as ready, using CDB data for the issued operand. This gives back-to-back issue: fu_valid is asserted after E (1 cycle from broadcast).
  - Undefined: 2-cycle wakeup-to-issue latency as above.

Decomposition:
- Shared package iq_pkg:
  - iq_entry_t struct {valid, op, tag_rd, tag_rs1/2, rdy1/2, data1/2, rob_index}.
  - OP_W, TAG_W, ROB_W, DATA_W defaults.
  - CDB port count constant shared with functional_unit.
- Sub-module iq_select: combinational oldest-first picker. Takes an eligible vector and fu_ready, and produces per-FU entry index and per-FU grant.

Test Plan:
- Reset/idle: rst=0 mid-run with 5 entries → count=0, iq_stall=0, all fu_valid=0 immediately; entries are gone after release.
- Ready dispatch: 3 dispatches with both sources ready (add tags 1,2,3), fu_ready=111. After the first issue cycle, each instruction appears on fu port 0 one cycle after its dispatch, in order, with correct rob_index.
- Wakeup: dispatch tag_rd=7 with rs1 tag 5 not ready; cdb_tags[1]=5, data 0x1234 two cycles later → fu_rs1=0x1234 two cycles after broadcast (one cycle with ISSUE_QUEUE_WAKEUP_BYPASS_EN).
- Oldest-first/skip: 4 ready entries, fu_ready=101 → oldest two issue on ports 0 and 2, port 1 fu_valid=0, count drops 4→2.
- Full: DEPTH dispatches with unready sources → iq_stall=1. A further in_valid is ignored. A CDB wakeup of one entry gives count DEPTH−1 after issue, and iq_stall deasserts.
- Flush with simultaneous dispatch and CDB → count=0 next cycle, no fu_valid.
